mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Two-master, one-slave arbiter for the SoC's single memory port. Master 0 is CPU instruction fetch; master 1 is
//  CPU load/store. Grants at most one access per cycle to a fixed-latency memory and routes each response back to
//  the master that issued it. Sits between open_risc_v and the memory in the SoC top.
// PARAMETERS
//  ADDR_W   32  address width, passed through unchanged
//  DATA_W   32  data width
//  MEM_LAT  1   memory read latency in cycles (>=1); mem_rdata_i is valid MEM_LAT cycles after mem_en_o
//  CNT_W    16  width of the saturating conflict counter
// PORTS
//  clk            in   1       clock, all state on rising edge
//  rst_n          in   1       asynchronous active-low reset
//  m0_req_i       in   1       fetch request; addr held stable until granted
//  m0_addr_i      in   ADDR_W  fetch address
//  m0_gnt_o       out  1       fetch request accepted this cycle
//  m0_rvalid_o    out  1       fetch response valid (one-cycle pulse)
//  m0_rdata_o     out  DATA_W  fetch response data
//  m1_req_i       in   1       load/store request; addr/we/wdata held until granted
//  m1_we_i        in   1       1 = write, 0 = read
//  m1_addr_i      in   ADDR_W  load/store address
//  m1_wdata_i     in   DATA_W  store data
//  m1_gnt_o       out  1       load/store request accepted this cycle
//  m1_rvalid_o    out  1       load/store response valid (reads return data, writes ack with rdata 0)
//  m1_rdata_o     out  DATA_W  load response data
//  mem_en_o       out  1       memory access this cycle
//  mem_we_o       out  1       memory write enable
//  mem_addr_o     out  ADDR_W  memory address
//  mem_wdata_o    out  DATA_W  memory write data
//  mem_rdata_i    in   DATA_W  memory read data, MEM_LAT cycles after mem_en_o
//  conflict_cnt_o out  CNT_W   cycles with both req high (one denied), saturates at all-ones
// BEHAVIOUR
//  - Reset: all outputs 0; response pipeline emptied; conflict counter 0; last-grant register = master 1.
//  - Grant is combinational in the request cycle: mem_en_o = m0_req_i | m1_req_i; exactly one gnt_o when mem_en_o.
//  - Memory address, we and wdata are muxed from the granted master; mem_we_o is 0 for master 0.
//  - A request is accepted on the cycle its gnt_o is 1; the master may change or drop req the next cycle.
//  - Response pipeline: per issue, push {valid, owner, we} into an MEM_LAT-deep shift register. It advances every cycle.
//  - At the pipeline head, when valid, pulse the owner's rvalid_o. Drive rdata_o = mem_rdata_i for reads, 0 for writes.
//  - The other master's rvalid_o stays 0 and its rdata_o holds 0.
//  - Throughput: one access per cycle back to back; no bubble between masters.
//  - Conflict: both req high -> increment conflict_cnt_o by 1, no wrap at max.
//  - Async reset mid-flight: in-flight entries are discarded; no rvalid is produced for them after reset releases.
//  - A master with req low never gets gnt; gnt never asserts without mem_en_o.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN undefined: fixed priority; master 1 (load/store) always wins a conflict.
//  ARB_ROUND_ROBIN_EN defined: on conflict, grant the master that did not win the previous conflict.
//    The last-grant register updates only on conflict cycles. Master 0 wins the first conflict after reset.
// STRUCTURE
//  Package soc_bus_pkg: ADDR_W/DATA_W defaults, master-id constants (MST_IFETCH=0, MST_LSU=1),
//  response-entry struct {valid, owner, we}.
//  Sub-module arb_rsp_pipe: MEM_LAT-deep owner/we shift register with async clear; outputs the head entry.
//  Top level: grant logic, address/data mux, response demux, conflict counter.
// TESTING
//  1 m0_req only, addr 0x10, MEM_LAT=1 -> m0_gnt same cycle, mem_addr 0x10; next cycle m0_rvalid, m0_rdata=mem_rdata.
//  2 m1 write 0x20 data 0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF; next cycle m1_rvalid=1, m1_rdata=0, m0_rvalid=0.
//  3 both req held 4 cycles, fixed priority -> m1 granted all 4, m0 none, conflict_cnt=4.
//  4 Same as 3 with ARB_ROUND_ROBIN_EN -> grants m0,m1,m0,m1; conflict_cnt=4.
//  5 MEM_LAT=3, alternating m0/m1 issues every cycle -> responses arrive 3 cycles later in issue order, each to
//    the correct owner.
//  6 rst_n low while 2 reads in flight -> no rvalid after release; counter 0; saturation check with CNT_W=4 stops at 15.

Source files
------------

// File: rtl/soc_bus_pkg.sv
// Shared bus types for the SoC memory arbiter.
// Master ids and the response-pipeline entry.
package soc_bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  typedef enum logic {
    MST_IFETCH = 1'b0,
    MST_LSU    = 1'b1
  } mst_id_e;

  typedef struct packed {
    logic    valid;
    mst_id_e owner;
    logic    we;
  } rsp_ent_t;

  function automatic mst_id_e mst_of(
    input logic is_lsu
  );
    return is_lsu ? MST_LSU : MST_IFETCH;
  endfunction

endpackage

// File: rtl/arb_rsp_pipe.sv
// Fixed-depth response tracker for the memory arbiter.
// Entries shift one slot per cycle; head is MEM_LAT old.
module arb_rsp_pipe
  import soc_bus_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  rsp_ent_t push_i,
  output rsp_ent_t head_o
);

  rsp_ent_t [MEM_LAT-1:0] q;

  // shift issued entries toward the head, clear on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q[0] <= push_i;
      for (int i = 1; i < MEM_LAT; i++) begin
        q[i] <= q[i-1];
      end
    end
  end

  assign head_o = q[MEM_LAT-1];

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the single memory port.
// ARB_ROUND_ROBIN_EN: alternate winners on conflict.
module mem_bus_arbiter
  import soc_bus_pkg::*;
#(
  parameter int ADDR_W  = BUS_ADDR_W,
  parameter int DATA_W  = BUS_DATA_W,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [CNT_W-1:0]  conflict_cnt_o
);

  logic             any_req;
  logic             conflict;
  logic             win_lsu;
  logic             rr_lsu;
  rsp_ent_t         push;
  rsp_ent_t         head;
  logic [CNT_W-1:0] cnt_q;

  assign any_req  = m0_req_i | m1_req_i;
  assign conflict = m0_req_i & m1_req_i;

`ifdef ARB_ROUND_ROBIN_EN
  mst_id_e last_q;

  // remember the winner of the most recent conflict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= MST_LSU;
    end else if (conflict) begin
      last_q <= mst_of(win_lsu);
    end
  end

  assign rr_lsu = (last_q == MST_IFETCH);
`else
  assign rr_lsu = 1'b1;
`endif

  // pick the granted master
  always_comb begin
    win_lsu = 1'b0;
    unique case (1'b1)
      conflict:               win_lsu = rr_lsu;
      (m1_req_i & ~m0_req_i): win_lsu = 1'b1;
      default:                win_lsu = 1'b0;
    endcase
  end

  assign m0_gnt_o = any_req & ~win_lsu;
  assign m1_gnt_o = any_req & win_lsu;

  assign mem_en_o    = any_req;
  assign mem_we_o    = win_lsu & m1_we_i;
  assign mem_addr_o  = win_lsu ? m1_addr_i : m0_addr_i;
  assign mem_wdata_o = win_lsu ? m1_wdata_i : '0;

  assign push.valid = any_req;
  assign push.owner = mst_of(win_lsu);
  assign push.we    = mem_we_o;

  arb_rsp_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_rsp (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .head_o (head)
  );

  // route the head response to its owner
  always_comb begin
    m0_rvalid_o = 1'b0;
    m1_rvalid_o = 1'b0;
    m0_rdata_o  = '0;
    m1_rdata_o  = '0;
    if (head.valid) begin
      if (head.owner == MST_LSU) begin
        m1_rvalid_o = 1'b1;
        m1_rdata_o  = head.we ? '0 : mem_rdata_i;
      end else begin
        m0_rvalid_o = 1'b1;
        m0_rdata_o  = head.we ? '0 : mem_rdata_i;
      end
    end
  end

  // count conflict cycles, holding at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (conflict && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: two instances share stimulus,
// one with MEM_LAT=1/CNT_W=16, one with MEM_LAT=3/CNT_W=4.
module tb_mem_bus_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        r0, r1, we1;
  logic [31:0] a0, a1, wd;

  logic        a_g0, a_g1, a_v0, a_v1, a_en, a_we;
  logic [31:0] a_d0, a_d1, a_ma, a_mw, a_rd;
  logic [15:0] a_cnt;

  logic        b_g0, b_g1, b_v0, b_v1, b_en, b_we;
  logic [31:0] b_d0, b_d1, b_ma, b_mw, b_rd;
  logic [3:0]  b_cnt;

  mem_bus_arbiter #(
    .MEM_LAT (1),
    .CNT_W   (16)
  ) dut_a (
    .clk            (clk),
    .rst_n          (rst_n),
    .m0_req_i       (r0),
    .m0_addr_i      (a0),
    .m0_gnt_o       (a_g0),
    .m0_rvalid_o    (a_v0),
    .m0_rdata_o     (a_d0),
    .m1_req_i       (r1),
    .m1_we_i        (we1),
    .m1_addr_i      (a1),
    .m1_wdata_i     (wd),
    .m1_gnt_o       (a_g1),
    .m1_rvalid_o    (a_v1),
    .m1_rdata_o     (a_d1),
    .mem_en_o       (a_en),
    .mem_we_o       (a_we),
    .mem_addr_o     (a_ma),
    .mem_wdata_o    (a_mw),
    .mem_rdata_i    (a_rd),
    .conflict_cnt_o (a_cnt)
  );

  mem_bus_arbiter #(
    .MEM_LAT (3),
    .CNT_W   (4)
  ) dut_b (
    .clk            (clk),
    .rst_n          (rst_n),
    .m0_req_i       (r0),
    .m0_addr_i      (a0),
    .m0_gnt_o       (b_g0),
    .m0_rvalid_o    (b_v0),
    .m0_rdata_o     (b_d0),
    .m1_req_i       (r1),
    .m1_we_i        (we1),
    .m1_addr_i      (a1),
    .m1_wdata_i     (wd),
    .m1_gnt_o       (b_g1),
    .m1_rvalid_o    (b_v1),
    .m1_rdata_o     (b_d1),
    .mem_en_o       (b_en),
    .mem_we_o       (b_we),
    .mem_addr_o     (b_ma),
    .mem_wdata_o    (b_mw),
    .mem_rdata_i    (b_rd),
    .conflict_cnt_o (b_cnt)
  );

  function automatic logic [31:0] f(input logic [31:0] ad);
    return ad ^ 32'hA5A5_5A5A;
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memory models: data is a function of the address seen
  logic [31:0] b_p0, b_p1;
  always @(posedge clk) begin
    a_rd <= a_en ? f(a_ma) : 32'h0;
    b_p0 <= b_en ? f(b_ma) : 32'h0;
    b_p1 <= b_p0;
    b_rd <= b_p1;
  end

  typedef struct {
    int          due;
    logic        own;
    logic [31:0] dat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   failures = 0;
  int   ca = 0;
  int   cb = 0;
  logic last = 1'b1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rsp(input string n,
                     input logic v0, input logic v1,
                     input logic [31:0] d0,
                     input logic [31:0] d1,
                     input bit due, input exp_t e);
    logic x0, x1;
    x0 = due && (e.own == 1'b0);
    x1 = due && (e.own == 1'b1);
    chk({n, "_rv0"}, {31'b0, v0}, {31'b0, x0});
    chk({n, "_rv1"}, {31'b0, v1}, {31'b0, x1});
    chk({n, "_rd0"}, d0, x0 ? e.dat : 32'h0);
    chk({n, "_rd1"}, d1, x1 ? e.dat : 32'h0);
  endtask

  task automatic step(input logic q0, input logic [31:0] ad0,
                      input logic q1, input logic w,
                      input logic [31:0] ad1,
                      input logic [31:0] dat);
    logic en, cf, win;
    logic [31:0] ea, ed;
    exp_t ex;
    bit due;
    @(negedge clk);
    r0 = q0; a0 = ad0; r1 = q1; we1 = w;
    a1 = ad1; wd = dat;
    #1;
    en  = q0 | q1;
    cf  = q0 & q1;
    win = cf ? (RR ? ~last : 1'b1) : q1;
    ea  = win ? ad1 : ad0;
    ed  = (win & w) ? 32'h0 : f(ea);
    chk("a_gnt0", {31'b0, a_g0}, {31'b0, en & ~win});
    chk("a_gnt1", {31'b0, a_g1}, {31'b0, en & win});
    chk("b_gnt0", {31'b0, b_g0}, {31'b0, en & ~win});
    chk("b_gnt1", {31'b0, b_g1}, {31'b0, en & win});
    chk("a_en", {31'b0, a_en}, {31'b0, en});
    chk("b_en", {31'b0, b_en}, {31'b0, en});
    if (en) begin
      chk("a_we", {31'b0, a_we}, {31'b0, win & w});
      chk("b_we", {31'b0, b_we}, {31'b0, win & w});
      chk("a_addr", a_ma, ea);
      chk("b_addr", b_ma, ea);
      if (win) begin
        chk("a_wdata", a_mw, dat);
        chk("b_wdata", b_mw, dat);
      end
    end
    chk("a_cnt", {16'b0, a_cnt}, ca[31:0]);
    chk("b_cnt", {28'b0, b_cnt}, cb[31:0]);
    ex  = '{0, 1'b0, 32'h0};
    due = (qa.size() > 0) && (qa[0].due == cyc);
    if (due) ex = qa.pop_front();
    rsp("a", a_v0, a_v1, a_d0, a_d1, due, ex);
    ex  = '{0, 1'b0, 32'h0};
    due = (qb.size() > 0) && (qb[0].due == cyc);
    if (due) ex = qb.pop_front();
    rsp("b", b_v0, b_v1, b_d0, b_d1, due, ex);
    if (en) begin
      qa.push_back('{cyc + 1, win, ed});
      qb.push_back('{cyc + 3, win, ed});
    end
    if (cf) begin
      if (ca < 65535) ca++;
      if (cb < 15) cb++;
      last = win;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    r0 = 0; r1 = 0; we1 = 0;
    #2 rst_n = 1'b0;
    qa.delete();
    qb.delete();
    ca = 0; cb = 0; last = 1'b1;
    #1;
    chk("rst_b_rv0", {31'b0, b_v0}, 32'h0);
    chk("rst_b_rv1", {31'b0, b_v1}, 32'h0);
    chk("rst_a_cnt", {16'b0, a_cnt}, 32'h0);
    chk("rst_b_cnt", {28'b0, b_cnt}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    r0 = 0; r1 = 0; we1 = 0;
    a0 = 0; a1 = 0; wd = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("init_en", {31'b0, a_en}, 32'h0);
    chk("init_rv", {30'b0, a_v0, b_v1}, 32'h0);
    chk("init_cnt", {16'b0, a_cnt}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // single fetch, then single store
    step(1, 32'h10, 0, 0, 0, 0);
    idle(3);
    step(0, 0, 1, 1, 32'h20, 32'hDEADBEEF);
    idle(3);

    // four conflict cycles
    for (int i = 0; i < 4; i++)
      step(1, 32'h30 + i, 1, 0, 32'h40 + i, 0);
    idle(3);
    chk("conflict4_a", {16'b0, a_cnt}, 32'd4);
    chk("conflict4_b", {28'b0, b_cnt}, 32'd4);

    // alternating back-to-back issues
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        step(1, 32'h100 + i, 0, 0, 0, 0);
      else
        step(0, 0, 1, i == 3, 32'h200 + i, 32'h55 + i);
    end
    idle(4);

    // reset with two reads in flight
    step(1, 32'h300, 0, 0, 0, 0);
    step(0, 0, 1, 0, 32'h304, 0);
    do_reset();
    idle(5);

    // long conflict run saturates the 4-bit counter
    for (int i = 0; i < 18; i++)
      step(1, 32'h400 + i, 1, 0, 32'h500 + i, 0);
    idle(4);
    chk("sat_b", {28'b0, b_cnt}, 32'd15);
    chk("sat_a", {16'b0, a_cnt}, 32'd18);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
